// File: rtl/axis_tx_fifo.sv
// AXI4-Stream master fed by a first-word-fall-through FIFO.
// TLAST is either taken from the producer or generated from a per-packet beat count.
module axis_tx_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8,
    parameter int USER_WIDTH = 3,
    parameter int ID_WIDTH   = 2,
    parameter int DEST_WIDTH = 1,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic [DATA_WIDTH/8-1:0]   in_keep,
    input  logic                      in_last,
    input  logic [USER_WIDTH-1:0]     in_user,
    input  logic [ID_WIDTH-1:0]       in_id,
    input  logic [DEST_WIDTH-1:0]     in_dest,
    input  logic                      cfg_auto_last,
    input  logic [LEN_WIDTH-1:0]      cfg_pkt_len,
    input  logic                      TREADY,
    output logic                      TVALID,
    output logic [DATA_WIDTH-1:0]     TDATA,
    output logic [DATA_WIDTH/8-1:0]   TKEEP,
    output logic [DATA_WIDTH/8-1:0]   TSTRB,
    output logic                      TLAST,
    output logic [USER_WIDTH-1:0]     TUSER,
    output logic [ID_WIDTH-1:0]       TID,
    output logic [DEST_WIDTH-1:0]     TDEST,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      pkt_done
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_WIDTH + KW + USER_WIDTH + ID_WIDTH + DEST_WIDTH + 1;

    logic [EW-1:0]        mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 rdy_en;
    logic [LEN_WIDTH-1:0] bcnt;
    logic                 lat_auto;
    logic [LEN_WIDTH-1:0] lat_len;

    logic                 wr_en;
    logic                 rd_en;
    logic                 first_beat;
    logic                 eff_auto;
    logic [LEN_WIDTH-1:0] eff_len;
    logic [LEN_WIDTH-1:0] cfg_len_min1;
    logic                 last_bit;
    logic [EW-1:0]        head;

    logic [DATA_WIDTH-1:0] h_data;
    logic [KW-1:0]         h_keep;
    logic [USER_WIDTH-1:0] h_user;
    logic [ID_WIDTH-1:0]   h_id;
    logic [DEST_WIDTH-1:0] h_dest;
    logic                  h_last;

    // rdy_en keeps in_ready low while in reset, when count alone would report space
    assign in_ready = rdy_en && (count < CW'(DEPTH));
    assign TVALID   = (count != '0);
    assign wr_en    = in_valid && in_ready;
    assign rd_en    = TVALID && TREADY;

    // The first beat of a packet uses live config; later beats use the latched copy
    assign first_beat   = (bcnt == '0);
    assign cfg_len_min1 = (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;
    assign eff_auto     = first_beat ? cfg_auto_last : lat_auto;
    assign eff_len      = first_beat ? cfg_len_min1 : lat_len;
    assign last_bit     = eff_auto ? (bcnt == eff_len - LEN_WIDTH'(1)) : in_last;

    always_ff @(posedge ACLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= {in_data, in_keep, in_user, in_id, in_dest, last_bit};
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rdy_en   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            bcnt     <= '0;
            lat_auto <= 1'b0;
            lat_len  <= LEN_WIDTH'(1);
            pkt_done <= 1'b0;
        end else begin
            rdy_en   <= 1'b1;
            pkt_done <= rd_en && TLAST;
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                bcnt   <= last_bit ? '0 : bcnt + LEN_WIDTH'(1);
                if (first_beat) begin
                    lat_auto <= cfg_auto_last;
                    lat_len  <= cfg_len_min1;
                end
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !rd_en) begin
                count <= count + CW'(1);
            end else if (rd_en && !wr_en) begin
                count <= count - CW'(1);
            end
        end
    end

    assign head = mem[rd_ptr];
    assign {h_data, h_keep, h_user, h_id, h_dest, h_last} = head;

    // Payload reads as zero whenever nothing valid is presented
    assign TDATA = TVALID ? h_data : '0;
    assign TKEEP = TVALID ? h_keep : '0;
    assign TSTRB = TKEEP;
    assign TLAST = TVALID ? h_last : 1'b0;
    assign TUSER = TVALID ? h_user : '0;
    assign TID   = TVALID ? h_id   : '0;
    assign TDEST = TVALID ? h_dest : '0;

endmodule

// File: tb/tb_axis_tx_fifo.sv
// Directed bench for axis_tx_fifo: pass/auto TLAST, full-FIFO backpressure and mid-packet reset.
module tb_axis_tx_fifo;

    localparam int DW = 64;
    localparam int KW = DW / 8;

    logic           ACLK = 1'b0;
    logic           ARESETn;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic [KW-1:0]  in_keep;
    logic           in_last;
    logic [2:0]     in_user;
    logic [1:0]     in_id;
    logic [0:0]     in_dest;
    logic           cfg_auto_last;
    logic [7:0]     cfg_pkt_len;
    logic           TREADY;
    logic           TVALID;
    logic [DW-1:0]  TDATA;
    logic [KW-1:0]  TKEEP;
    logic [KW-1:0]  TSTRB;
    logic           TLAST;
    logic [2:0]     TUSER;
    logic [1:0]     TID;
    logic [0:0]     TDEST;
    logic [3:0]     count;
    logic           pkt_done;

    int n_chk  = 0;
    int n_pass = 0;
    int pulses = 0;

    axis_tx_fifo dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_keep(in_keep),
        .in_last(in_last), .in_user(in_user), .in_id(in_id), .in_dest(in_dest),
        .cfg_auto_last(cfg_auto_last), .cfg_pkt_len(cfg_pkt_len),
        .TREADY(TREADY), .TVALID(TVALID), .TDATA(TDATA), .TKEEP(TKEEP), .TSTRB(TSTRB),
        .TLAST(TLAST), .TUSER(TUSER), .TID(TID), .TDEST(TDEST),
        .count(count), .pkt_done(pkt_done)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Auto-mode table: cfg_pkt_len applied per beat, and the TLAST each beat must carry
    logic [7:0] len_tab  [10] = '{8'd4, 8'd4, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd0, 8'd0};
    logic       last_tab [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        ARESETn = 1'b0; in_valid = 1'b0; in_data = '0; in_keep = '1; in_last = 1'b0;
        in_user = '0; in_id = '0; in_dest = '0; cfg_auto_last = 1'b0; cfg_pkt_len = 8'd1;
        TREADY = 1'b0;

        // reset state
        tick(); tick();
        chk("rst_tvalid",   64'(TVALID),   64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_count",    64'(count),    64'd0);
        chk("rst_tdata",    TDATA,         64'd0);
        chk("rst_pkt_done", 64'(pkt_done), 64'd0);
        #2 ARESETn = 1'b1;
        tick();
        chk("rel_in_ready", 64'(in_ready), 64'd1);

        // pass mode, 3-beat packet, sink always ready
        TREADY = 1'b1;
        in_valid = 1'b1; in_data = 64'h11;
        tick();
        chk("p_d0", TDATA, 64'h11);
        chk("p_l0", 64'(TLAST), 64'd0);
        in_data = 64'h22; in_user = 3'd5; in_id = 2'd2; in_dest = 1'b1;
        tick();
        chk("p_d1", TDATA, 64'h22);
        chk("p_u1", 64'({TUSER, TID, TDEST}), 64'({3'd5, 2'd2, 1'b1}));
        chk("p_cnt1", 64'(count), 64'd1);
        in_data = 64'h33; in_last = 1'b1; in_keep = 8'h0F; in_user = '0; in_id = '0; in_dest = '0;
        tick();
        chk("p_d2", TDATA, 64'h33);
        chk("p_l2", 64'(TLAST), 64'd1);
        chk("p_keep2", 64'(TKEEP), 64'h0F);
        chk("p_strb2", 64'(TSTRB), 64'h0F);
        chk("p_done_early", 64'(pkt_done), 64'd0);
        in_valid = 1'b0; in_last = 1'b0; in_keep = '1;
        tick();
        chk("p_done", 64'(pkt_done), 64'd1);
        chk("p_cnt_end", 64'(count), 64'd0);
        chk("p_tvalid_end", 64'(TVALID), 64'd0);
        chk("p_tdata_gated", TDATA, 64'd0);
        tick();
        chk("p_done_clr", 64'(pkt_done), 64'd0);

        // fill to full with sink stalled
        TREADY = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 64'h100 + 64'(i);
            tick();
        end
        chk("f_cnt", 64'(count), 64'd8);
        chk("f_in_ready", 64'(in_ready), 64'd0);
        chk("f_head", TDATA, 64'h100);
        in_data = 64'h108;
        tick(); tick();
        chk("f_cnt_hold", 64'(count), 64'd8);
        chk("f_head_hold", TDATA, 64'h100);
        chk("f_tvalid_hold", 64'(TVALID), 64'd1);
        // read while full: no write on that edge
        TREADY = 1'b1;
        tick();
        chk("f_rd_only_cnt", 64'(count), 64'd7);
        chk("f_rd_only_rdy", 64'(in_ready), 64'd1);
        chk("f_rd_only_head", TDATA, 64'h101);
        tick();
        chk("f_rw_cnt", 64'(count), 64'd7);
        in_data = 64'h109; in_last = 1'b1;
        tick();
        chk("f_rw2_cnt", 64'(count), 64'd7);
        in_valid = 1'b0; in_last = 1'b0;
        for (int k = 3; k < 10; k++) begin
            chk("f_order", TDATA, 64'h100 + 64'(k));
            chk("f_last", 64'(TLAST), (k == 9) ? 64'd1 : 64'd0);
            tick();
        end
        chk("f_cnt_end", 64'(count), 64'd0);
        chk("f_done", 64'(pkt_done), 64'd1);

        // auto mode, 4-beat packets
        cfg_auto_last = 1'b1; cfg_pkt_len = 8'd4; in_valid = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            in_data = 64'h200 + 64'(i);
            tick();
            chk("a4_data", TDATA, 64'h200 + 64'(i));
            chk("a4_last", 64'(TLAST), ((i % 4) == 3) ? 64'd1 : 64'd0);
            if (pkt_done) pulses++;
        end
        in_valid = 1'b0;
        tick();
        if (pkt_done) pulses++;
        chk("a4_pulses", 64'(pulses), 64'd3);

        // mid-packet length change, then length 0
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cfg_pkt_len = len_tab[i];
            in_data = 64'h500 + 64'(i);
            tick();
            chk("alen_data", TDATA, 64'h500 + 64'(i));
            chk("alen_last", 64'(TLAST), 64'(last_tab[i]));
        end
        in_valid = 1'b0;
        tick();
        chk("alen_cnt", 64'(count), 64'd0);

        // reset mid-packet with 5 beats buffered
        TREADY = 1'b0; cfg_pkt_len = 8'd8; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 64'h300 + 64'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("r_cnt5", 64'(count), 64'd5);
        ARESETn = 1'b0;
        #1;
        chk("r_tvalid", 64'(TVALID), 64'd0);
        chk("r_tlast",  64'(TLAST),  64'd0);
        chk("r_tdata",  TDATA,       64'd0);
        chk("r_count",  64'(count),  64'd0);
        chk("r_done",   64'(pkt_done), 64'd0);
        chk("r_ready",  64'(in_ready), 64'd0);
        tick();
        #2 ARESETn = 1'b1;
        tick();
        chk("r_rel_ready", 64'(in_ready), 64'd1);
        chk("r_rel_tvalid", 64'(TVALID), 64'd0);
        cfg_pkt_len = 8'd2; in_valid = 1'b1; in_data = 64'h400; TREADY = 1'b1;
        tick();
        chk("r_new_d0", TDATA, 64'h400);
        chk("r_new_l0", 64'(TLAST), 64'd0);
        in_data = 64'h401;
        tick();
        chk("r_new_d1", TDATA, 64'h401);
        chk("r_new_l1", 64'(TLAST), 64'd1);
        in_valid = 1'b0;
        tick();
        chk("r_new_cnt", 64'(count), 64'd0);
        chk("r_new_done", 64'(pkt_done), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axis_tx_fifo.md
Name: axis_tx_fifo

Overview:
Parametrised AXI4-Stream master with an internal first-word-fall-through FIFO. It sits between the SHA3 datapath (simple valid/ready producer) and the downstream AXI-Stream sink. Compared with the single-register transmitter it adds:
- configurable data/sideband widths and buffer depth;
- TKEEP/TSTRB passthrough;
- two TLAST modes: producer-supplied, or auto-generated from a programmable beat count;
- a packet-completion pulse.

Parameters:
DATA_WIDTH, 64, TDATA width in bits; multiple of 8
DEPTH, 8, FIFO entries; power of 2, >= 2
USER_WIDTH, 3, TUSER width
ID_WIDTH, 2, TID width
DEST_WIDTH, 1, TDEST width
LEN_WIDTH, 8, width of cfg_pkt_len

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETn  in  1  asynchronous active-low reset
in_valid  in  1  producer beat valid
in_ready  out  1  FIFO can accept a beat
in_data  in  DATA_WIDTH  producer data
in_keep  in  DATA_WIDTH/8  byte-valid mask
in_last  in  1  end of packet (pass mode only)
in_user  in  USER_WIDTH  sideband, stored per beat
in_id  in  ID_WIDTH  stream ID, stored per beat
in_dest  in  DEST_WIDTH  destination, stored per beat
cfg_auto_last  in  1  1 = TLAST from beat counter; 0 = TLAST from in_last
cfg_pkt_len  in  LEN_WIDTH  beats per packet in auto mode; 0 treated as 1
TREADY  in  1  sink ready
TVALID  out  1  head entry valid
TDATA  out  DATA_WIDTH  head data
TKEEP  out  DATA_WIDTH/8  head keep
TSTRB  out  DATA_WIDTH/8  equal to TKEEP
TLAST  out  1  head last flag
TUSER  out  USER_WIDTH  head user
TID  out  ID_WIDTH  head id
TDEST  out  DEST_WIDTH  head dest
count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
pkt_done  out  1  one-cycle pulse after a TLAST beat is accepted

Behaviour:
Reset:
- On ARESETn low (asynchronous), clear write/read pointers, count, beat counter, latched config and pkt_done.
- FIFO contents are discarded; memory itself is not reset.
- While in reset and after it: TVALID=0, in_ready=0 during reset and 1 on the first edge after release, count=0, pkt_done=0.
- Payload outputs (TDATA, TKEEP, TSTRB, TLAST, TUSER, TID, TDEST) are forced to 0 whenever TVALID=0, so their reset value is 0.

Write side:
- in_ready = (count < DEPTH), taken from registered count.
- A write occurs when in_valid & in_ready. The entry stores {data, keep, user, id, dest, last_bit}.
- No write bypass. When full, in_ready stays 0 even if a read happens in the same cycle; the freed slot is visible next cycle.

Read side:
- TVALID = (count != 0). Payload = mem[rd_ptr], gated by TVALID.
- A read occurs when TVALID & TREADY.
- Latency: a beat written at edge k is visible with TVALID=1 after edge k (FWFT, 1 cycle). No empty bypass.
- AXI rule: once TVALID=1, payload is stable until TREADY handshake; TVALID never drops without a handshake, except on reset.

Occupancy:
- Write only: count+1. Read only: count-1. Both or neither: unchanged.
- Pointers wrap modulo DEPTH.

TLAST generation (beat counter on the write side, bcnt, LEN_WIDTH bits):
- On the first beat of a packet (bcnt==0), latch cfg_auto_last and max(cfg_pkt_len,1). These latched values govern the whole packet; config changes mid-packet have no effect until the next packet.
- Auto mode: last_bit = (bcnt == len-1); in_last is ignored.
- Pass mode: last_bit = in_last.
- bcnt increments per written beat and returns to 0 on the beat written with last_bit=1.
- cfg_pkt_len=1 gives TLAST on every beat.

pkt_done:
- Registered. Equals 1 in the cycle following an edge where TVALID & TREADY & TLAST; otherwise 0.

Test Plan:
- Reset, then pass mode, DEPTH=8: write 3 beats 0x11,0x22,0x33 (last on 0x33) with TREADY=1 -> each appears 1 cycle after write; TLAST only with 0x33; pkt_done=1 one cycle after that handshake; count returns to 0.
- TREADY=0, write 10 beats continuously -> in_ready drops after 8 writes, count=8, TVALID=1 with TDATA held at beat 0; raise TREADY -> beats 0..9 delivered in order with no loss or duplication.
- Auto mode, cfg_pkt_len=4, in_last tied 0, 12 beats -> TLAST on beats 3, 7, 11; three pkt_done pulses.
- Auto mode, change cfg_pkt_len 4->2 after beat 1 of a packet -> current packet still ends at beat 3; the next packet ends every 2 beats. cfg_pkt_len=0 -> TLAST every beat.
- Full FIFO with simultaneous read and in_valid=1 -> no write that cycle, count=7 next cycle, then the write is accepted.
- Assert ARESETn low mid-packet with count=5 -> TVALID, TLAST, TDATA, count and pkt_done go to 0 immediately. After release, a new packet starts with bcnt=0, and the old data never appears.
